lite_sequencer: RTL and testbench

Instruction sequencer for the `lite` datapath (2-bit opcode, 8-bit `d1`, 10-bit `d2`, registered 8-bit `res`). It fetches 16-bit instruction words from an instruction memory over a request/valid handshake and decodes them. It issues datapath operations, writes results into a 4×8 register file, and handles jumps, conditional branches, output writes and halt.

---
 rtl/lite_pkg.sv | 56 +++++
 rtl/lite_regfile.sv | 29 ++
 rtl/lite_sequencer.sv | 150 +++++++++++++++
 tb/tb_lite_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lite_pkg.sv
// Shared definitions for the lite sequencer: instruction encodings, FSM states,
// field positions and datapath opcodes.
package lite_pkg;

    typedef enum logic [2:0] {
        OpNop   = 3'd0,
        OpPassA = 3'd1,
        OpPassB = 3'd2,
        OpLdi   = 3'd3,
        OpJmp   = 3'd4,
        OpBz    = 3'd5,
        OpOut   = 3'd6,
        OpHalt  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StWb,
        StHalt
    } state_e;

    localparam int unsigned InstrW   = 16;
    localparam int unsigned DataW    = 8;
    localparam int unsigned Dp2W     = 10;
    localparam int unsigned NumRegs  = 4;
    localparam int unsigned RegAddrW = 2;

    localparam int unsigned OpLsb  = 13;
    localparam int unsigned RdLsb  = 11;
    localparam int unsigned RaLsb  = 9;
    localparam int unsigned ImmLsb = 0;

    localparam logic [1:0] DpOpPassA = 2'b00;
    localparam logic [1:0] DpOpPassB = 2'b01;
    localparam logic [1:0] DpOpIdle  = 2'b11;

    function automatic op_e instr_op(input logic [InstrW-1:0] ir);
        return op_e'(ir[OpLsb +: 3]);
    endfunction

    function automatic logic [RegAddrW-1:0] instr_rd(input logic [InstrW-1:0] ir);
        return ir[RdLsb +: RegAddrW];
    endfunction

    function automatic logic [RegAddrW-1:0] instr_ra(input logic [InstrW-1:0] ir);
        return ir[RaLsb +: RegAddrW];
    endfunction

    function automatic logic [DataW-1:0] instr_imm(input logic [InstrW-1:0] ir);
        return ir[ImmLsb +: DataW];
    endfunction

endpackage

// File: rtl/lite_regfile.sv
// 4x8 register file: one combinational read port, one synchronous write port,
// synchronous reset of every entry to zero.
module lite_regfile
    import lite_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_we,
    input  logic [RegAddrW-1:0] i_waddr,
    input  logic [DataW-1:0]    i_wdata,
    input  logic [RegAddrW-1:0] i_raddr,
    output logic [DataW-1:0]    o_rdata
);

    logic [DataW-1:0] r_regs [NumRegs];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_regs[i_raddr];

endmodule

// File: rtl/lite_sequencer.sv
// Instruction sequencer for the lite datapath: fetches 16-bit words, decodes them,
// drives the datapath and writes results back into the register file.
module lite_sequencer
    import lite_pkg::*;
#(
    parameter int unsigned PC_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_halted,
    output logic              o_imem_req,
    output logic [PC_W-1:0]   o_imem_addr,
    input  logic              i_imem_valid,
    input  logic [InstrW-1:0] i_imem_data,
    output logic [1:0]        o_dp_opcode,
    output logic [DataW-1:0]  o_dp_d1,
    output logic [Dp2W-1:0]   o_dp_d2,
    input  logic [DataW-1:0]  i_dp_res,
    output logic [DataW-1:0]  o_out_data,
    output logic              o_out_valid
);

    state_e              r_state, w_state_next;
    logic [PC_W-1:0]     r_pc;
    logic [InstrW-1:0]   r_ir;
    logic [DataW-1:0]    r_out_data;

    op_e                 w_op;
    logic [RegAddrW-1:0] w_rd, w_ra;
    logic [DataW-1:0]    w_imm, w_ra_data, w_rf_wdata;
    logic [PC_W-1:0]     w_pc_inc, w_imm_pc;
    logic                w_rf_we;
    logic                w_unused_rsvd;

    assign w_op          = instr_op(r_ir);
    assign w_rd          = instr_rd(r_ir);
    assign w_ra          = instr_ra(r_ir);
    assign w_imm         = instr_imm(r_ir);
    assign w_unused_rsvd = r_ir[8];
    assign w_pc_inc      = r_pc + PC_W'(1);
    assign w_imm_pc      = PC_W'(w_imm);

    lite_regfile u_regfile (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_rf_we),
        .i_waddr (w_rd),
        .i_wdata (w_rf_wdata),
        .i_raddr (w_ra),
        .o_rdata (w_ra_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle, StHalt: if (i_start) w_state_next = StFetch;
            StFetch:        if (i_imem_valid) w_state_next = StDecode;
            StDecode: begin
                if (w_op == OpPassA || w_op == OpPassB) begin
                    w_state_next = StExec;
                end else if (w_op == OpHalt) begin
                    w_state_next = StHalt;
                end else begin
                    w_state_next = StFetch;
                end
            end
            StExec:  w_state_next = StWb;
            StWb:    w_state_next = StFetch;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_busy      = 1'b1;
        o_halted    = 1'b0;
        o_imem_req  = 1'b0;
        o_dp_opcode = DpOpIdle;
        o_dp_d1     = '0;
        o_dp_d2     = '0;
        o_out_valid = 1'b0;
        w_rf_we     = 1'b0;
        w_rf_wdata  = i_dp_res;
        unique case (r_state)
            StIdle:  o_busy = 1'b0;
            StHalt: begin
                o_busy   = 1'b0;
                o_halted = 1'b1;
            end
            StFetch: o_imem_req = 1'b1;
            StDecode: begin
                o_out_valid = (w_op == OpOut);
                if (w_op == OpLdi) begin
                    w_rf_we    = 1'b1;
                    w_rf_wdata = w_imm;
                end
            end
            StExec: begin
                if (w_op == OpPassA) begin
                    o_dp_opcode = DpOpPassA;
                    o_dp_d1     = w_ra_data;
                end else begin
                    o_dp_opcode = DpOpPassB;
                    o_dp_d2     = {2'b00, w_imm};
                end
            end
            StWb:    w_rf_we = 1'b1;
            default: ;
        endcase
    end

    // PC, IR and the held output value; PC stays on HALT so the halt address is visible.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc       <= '0;
            r_ir       <= '0;
            r_out_data <= '0;
        end else begin
            case (r_state)
                StIdle, StHalt: if (i_start) r_pc <= '0;
                StFetch:        if (i_imem_valid) r_ir <= i_imem_data;
                StDecode: begin
                    case (w_op)
                        OpJmp:   r_pc <= w_imm_pc;
                        OpBz:    r_pc <= (w_ra_data == '0) ? w_imm_pc : w_pc_inc;
                        OpHalt:  r_pc <= r_pc;
                        OpPassA, OpPassB: r_pc <= r_pc;
                        default: r_pc <= w_pc_inc;
                    endcase
                    if (w_op == OpOut) r_out_data <= w_ra_data;
                end
                StWb:    r_pc <= w_pc_inc;
                default: ;
            endcase
        end
    end

    assign o_imem_addr = r_pc;
    assign o_out_data  = o_out_valid ? w_ra_data : r_out_data;

endmodule

// File: tb/tb_lite_sequencer.sv
// Bench for lite_sequencer: ISA-level reference model with per-cycle compare,
// directed programs with literal expectations, then randomized programs.
module tb_lite_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_data;
    logic [7:0]  dp_res = 8'h00;
    logic        busy, halted, imem_req, out_valid;
    logic [7:0]  imem_addr, dp_d1, out_data;
    logic [1:0]  dp_opcode;
    logic [9:0]  dp_d2;

    logic [15:0] mem [256];
    int          checks = 0;
    int          errors = 0;
    int          valid_mode = 0;
    bit          chk_en = 1'b0;
    logic [7:0]  hs_addr [$];

    lite_sequencer #(.PC_W(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .o_busy       (busy),
        .o_halted     (halted),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_valid (imem_valid),
        .i_imem_data  (imem_data),
        .o_dp_opcode  (dp_opcode),
        .o_dp_d1      (dp_d1),
        .o_dp_d2      (dp_d2),
        .i_dp_res     (dp_res),
        .o_out_data   (out_data),
        .o_out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    // Datapath: registered pass of the selected operand.
    always @(posedge clk) begin
        dp_res <= (dp_opcode == 2'd0) ? dp_d1 : (dp_opcode == 2'd1) ? dp_d2[7:0] : 8'h00;
    end

    always @(posedge clk) begin
        #1;
        case (valid_mode)
            0:       imem_valid = 1'b1;
            1:       imem_valid = ($urandom % 3) != 0;
            default: imem_valid = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- ISA-level reference model ----------------
    typedef struct {
        bit [1:0] opc;
        bit [7:0] d1;
        bit [9:0] d2;
        bit       ov;
    } exp_t;

    exp_t     q [$];
    bit [7:0] m_pc = 8'h00;
    bit [7:0] m_r [4] = '{default: 8'h00};
    bit [7:0] m_out = 8'h00;
    bit       m_run = 1'b0;
    bit       m_halt = 1'b0;

    function automatic exp_t mk(bit [1:0] opc, bit [7:0] d1, bit [9:0] d2, bit ov);
        exp_t e;
        e.opc = opc; e.d1 = d1; e.d2 = d2; e.ov = ov;
        return e;
    endfunction

    // Runs one whole instruction and queues what each post-fetch cycle must show.
    task automatic execute(input bit [15:0] w);
        bit [2:0] op;
        bit [1:0] rd, ra;
        bit [7:0] imm;
        op = w[15:13]; rd = w[12:11]; ra = w[10:9]; imm = w[7:0];
        q.push_back(mk(2'd3, 8'h00, 10'h000, op == 3'd6));
        case (op)
            3'd1: begin
                q.push_back(mk(2'd0, m_r[ra], 10'h000, 1'b0));
                q.push_back(mk(2'd3, 8'h00, 10'h000, 1'b0));
                m_r[rd] = m_r[ra];
                m_pc = m_pc + 8'd1;
            end
            3'd2: begin
                q.push_back(mk(2'd1, 8'h00, {2'b00, imm}, 1'b0));
                q.push_back(mk(2'd3, 8'h00, 10'h000, 1'b0));
                m_r[rd] = imm;
                m_pc = m_pc + 8'd1;
            end
            3'd3: begin m_r[rd] = imm; m_pc = m_pc + 8'd1; end
            3'd4: m_pc = imm;
            3'd5: m_pc = (m_r[ra] == 8'h00) ? imm : m_pc + 8'd1;
            3'd6: begin m_out = m_r[ra]; m_pc = m_pc + 8'd1; end
            3'd7: begin m_halt = 1'b1; m_run = 1'b0; end
            default: m_pc = m_pc + 8'd1;
        endcase
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_pc = 8'h00; m_out = 8'h00; m_run = 1'b0; m_halt = 1'b0;
            for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        bit   fetch_cyc, idle_cyc;
        fetch_cyc = 1'b0;
        idle_cyc  = 1'b0;
        if (chk_en) begin
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("m_req", imem_req, 0);
                chk("m_busy", busy, 1);
                chk("m_halted", halted, 0);
                chk("m_opc", dp_opcode, e.opc);
                chk("m_d1", dp_d1, e.d1);
                chk("m_d2", dp_d2, e.d2);
                chk("m_ov", out_valid, e.ov);
            end else begin
                fetch_cyc = m_run;
                idle_cyc  = !m_run;
                chk("m_req", imem_req, m_run);
                chk("m_busy", busy, m_run);
                chk("m_halted", halted, m_halt);
                chk("m_addr", imem_addr, m_pc);
                chk("m_opc", dp_opcode, 2'd3);
                chk("m_d1", dp_d1, 0);
                chk("m_d2", dp_d2, 0);
                chk("m_ov", out_valid, 0);
            end
            chk("m_out", out_data, m_out);
            if (fetch_cyc && imem_valid) begin
                execute(mem[m_pc]);
            end else if (idle_cyc && start) begin
                m_run = 1'b1; m_halt = 1'b0; m_pc = 8'h00;
            end
        end
    end

    // Fetch addresses as the DUT actually transfers them.
    always @(negedge clk) begin
        if (imem_req && imem_valid && !rst) hs_addr.push_back(imem_addr);
    end

    // ---------------- directed + random stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    function automatic bit cond(input int which);
        case (which)
            0:       return out_valid;
            1:       return halted;
            default: return dp_opcode != 2'd3;
        endcase
    endfunction

    // Returns at a falling edge where the condition holds, or after the bound.
    task automatic wait_for(input int which, input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = cond(which);
        end
        chk(name, ok, 1);
    endtask

    task automatic check_reset_outputs(input string p);
        chk({p, "_req"}, imem_req, 0);
        chk({p, "_addr"}, imem_addr, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_halted"}, halted, 0);
        chk({p, "_opc"}, dp_opcode, 2'b11);
        chk({p, "_d1"}, dp_d1, 0);
        chk({p, "_d2"}, dp_d2, 0);
        chk({p, "_out"}, out_data, 0);
        chk({p, "_ov"}, out_valid, 0);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int n;
        bit found;
        clear_mem();
        step(); step(); step();
        chk_en = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");

        // LDI R1,0x15 ; OUT R1 ; HALT
        step();
        mem[0] = 16'h6815; mem[1] = 16'hC200; mem[2] = 16'hE000;
        rst = 1'b0;
        start = 1'b1;
        n = 0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1 start = 1'b0;
            n++;
            @(negedge clk);
            found = out_valid;
        end
        chk("ldi_out_seen", found, 1);
        chk("ldi_out_latency", n, 4);
        chk("ldi_out_data", out_data, 8'h15);
        wait_for(1, "ldi_halt");

        // PASSB R2,0xA5 ; OUT R2 ; HALT
        step(); rst = 1'b1; clear_mem();
        mem[0] = 16'h50A5; mem[1] = 16'hC400; mem[2] = 16'hE000;
        step(); step(); rst = 1'b0;
        start_pulse();
        wait_for(2, "passb_exec");
        chk("passb_opc", dp_opcode, 2'd1);
        chk("passb_d2", dp_d2, 10'h0A5);
        wait_for(0, "passb_out");
        chk("passb_data", out_data, 8'hA5);
        wait_for(1, "passb_halt");
        chk("halt_busy", busy, 0);
        chk("halt_pc", imem_addr, 8'h02);
        step();
        start_pulse();
        @(negedge clk);
        chk("restart_req", imem_req, 1);
        chk("restart_addr", imem_addr, 8'h00);

        // BZ both ways: 0:BZ R0,0x40  40:LDI R0,1  41:BZ R0,0x40  42:HALT
        step(); rst = 1'b1; clear_mem();
        mem[8'h00] = 16'hA040; mem[8'h40] = 16'h6001;
        mem[8'h41] = 16'hA040; mem[8'h42] = 16'hE000;
        step(); step(); rst = 1'b0;
        hs_addr.delete();
        start_pulse();
        wait_for(1, "bz_halt");
        chk("bz_count", hs_addr.size(), 4);
        if (hs_addr.size() == 4) begin
            chk("bz_taken", hs_addr[1], 8'h40);
            chk("bz_not_taken", hs_addr[3], 8'h42);
        end

        // Wait states: NOP ; HALT with imem_valid held low
        step(); rst = 1'b1; clear_mem();
        mem[0] = 16'h0000; mem[1] = 16'hE000;
        valid_mode = 2;
        step(); step(); rst = 1'b0;
        start_pulse();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wait_req", imem_req, 1);
            chk("wait_addr", imem_addr, 8'h00);
            chk("wait_busy", busy, 1);
        end
        valid_mode = 0;
        wait_for(1, "wait_halt");
        chk("wait_halt_pc", imem_addr, 8'h01);

        // PC wrap: 0:JMP 0xFF  FF:NOP
        step(); rst = 1'b1; clear_mem();
        mem[8'h00] = 16'h80FF;
        step(); step(); rst = 1'b0;
        hs_addr.delete();
        start_pulse();
        for (int i = 0; i < 40 && hs_addr.size() < 3; i++) @(negedge clk);
        chk("wrap_count", hs_addr.size() >= 3, 1);
        if (hs_addr.size() >= 3) begin
            chk("wrap_ff", hs_addr[1], 8'hFF);
            chk("wrap_00", hs_addr[2], 8'h00);
        end

        // Reset during EXEC of PASSB R1,0x33, then OUT R1 must see 0
        step(); rst = 1'b1; clear_mem();
        mem[0] = 16'h4833; mem[1] = 16'hE000;
        step(); step(); rst = 1'b0;
        start_pulse();
        wait_for(2, "rst_exec_reach");
        #1 rst = 1'b1;
        @(posedge clk);
        #1 mem[0] = 16'hC200;
        @(negedge clk);
        check_reset_outputs("rst_exec");
        step(); rst = 1'b0;
        start_pulse();
        wait_for(0, "rst_exec_out");
        chk("rst_exec_nowrite", out_data, 8'h00);

        // Randomized programs against the reference model
        valid_mode = 1;
        for (int p = 0; p < 6; p++) begin
            step(); rst = 1'b1; start = 1'b0;
            for (int i = 0; i < 256; i++) begin
                mem[i] = 16'($urandom);
                if (mem[i][15:13] == 3'd7 && ($urandom % 8) != 0) begin
                    mem[i][15:13] = 3'($urandom_range(0, 6));
                end
            end
            step(); step(); rst = 1'b0;
            start_pulse();
            for (int c = 0; c < 600; c++) begin
                step();
                start = ($urandom % 16) == 0;
                rst   = ($urandom % 200) == 0;
            end
        end
        step(); rst = 1'b0; start = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
